// File: rtl/pattern_detector.sv
// -----------------------------------------------------------------------------
// pattern_detector
//   Serial bit-pattern detector. Sampled bits are shifted into a PAT_LEN-bit
//   history register. A fill counter tracks how many valid bits the history
//   holds. A match fires when the history is full and equals the
//   (run-time loadable) pattern register. The match pulse is registered.
//
//   Optional feature: define PATTERN_DETECTOR_CNT_EN to build the saturating
//   match counter. Without it, match_cnt is tied to 0 and cnt_clr is ignored.
//
// Parameters
//   PAT_LEN  pattern length in bits (2..16)
//   PATTERN  reset-time pattern, MSB = first bit received
//   CNT_W    match counter width (1..16)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         sample `in` on this edge
//   in         serial data bit
//   overlap    1 = overlapping detection, 0 = non-overlapping
//   pat_load   load `pat` into the pattern register (discards this edge's bit)
//   pat        new pattern value, MSB first-received
//   cnt_clr    synchronous clear of match_cnt (wins over a same-edge match)
//   out        registered one-cycle match pulse
//   match_cnt  saturating match count
// -----------------------------------------------------------------------------
module pattern_detector #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b0110,
  parameter int                 CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               in,
  input  logic               overlap,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat,
  input  logic               cnt_clr,
  output logic               out,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam int                FILL_W   = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);

  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [PAT_LEN-1:0] pat_q,  pat_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               out_q,  out_d;

  logic [PAT_LEN-1:0] hist_shift_s;
  logic [FILL_W-1:0]  fill_inc_s;
  logic               match_s;

  // Match evaluation on the post-shift history and post-increment fill.
  always_comb begin
    hist_shift_s = {hist_q[PAT_LEN-2:0], in};
    if (fill_q == FILL_MAX) begin
      fill_inc_s = FILL_MAX;
    end else begin
      fill_inc_s = fill_q + FILL_ONE;
    end
    match_s = en & ~pat_load & (fill_inc_s == FILL_MAX) & (hist_shift_s == pat_q);
  end

  // Next-state for history, fill, pattern and the match pulse.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    out_d  = 1'b0;
    if (pat_load) begin
      // The bit presented on a load edge is dropped; the history restarts.
      pat_d  = pat;
      fill_d = {FILL_W{1'b0}};
    end else if (en) begin
      hist_d = hist_shift_s;
      out_d  = match_s;
      if (match_s && !overlap) begin
        fill_d = {FILL_W{1'b0}};
      end else begin
        fill_d = fill_inc_s;
      end
    end else begin
      // Gap cycle: partial sequence is preserved, no pulse.
      out_d = 1'b0;
    end
  end

  // Detector state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= {PAT_LEN{1'b0}};
      fill_q <= {FILL_W{1'b0}};
      pat_q  <= PATTERN;
      out_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      out_q  <= out_d;
    end
  end

  assign out = out_q;

`ifdef PATTERN_DETECTOR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating counter next-state; clear has priority over a match.
  always_comb begin
    if (cnt_clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (match_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Match counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`else
  logic cnt_clr_unused_s;

  assign cnt_clr_unused_s = cnt_clr;
  assign match_cnt        = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/pattern_detector.md
PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 SHALL have parameter PAT_LEN, default 4: pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter PATTERN, default 4'b0110: reset-time pattern, PAT_LEN bits, MSB = first bit received.
REQ-003 SHALL have parameter CNT_W, default 8: match counter width, legal range 1..16.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 SHALL have port en, input, 1 bit: when high, in is sampled this edge.
REQ-007 SHALL have port in, input, 1 bit: serial data bit.
REQ-008 SHALL have port overlap, input, 1 bit: 1 = overlapping detection, 0 = non-overlapping.
REQ-009 SHALL have port pat_load, input, 1 bit: load pat into the pattern register.
REQ-010 SHALL have port pat, input, PAT_LEN bits: new pattern value, MSB first-received.
REQ-011 SHALL have port cnt_clr, input, 1 bit: synchronous clear of match_cnt.
REQ-012 SHALL have port out, output, 1 bit: registered one-cycle match pulse.
REQ-013 SHALL have port match_cnt, output, CNT_W bits: saturating match count.

Function
REQ-014 SHALL keep a PAT_LEN-bit history shift register; each edge with en=1 shifts in into the LSB.
REQ-015 SHALL keep a fill counter 0..PAT_LEN counting valid history bits, incremented per sampled bit, saturating at PAT_LEN.
REQ-016 SHALL declare a match on an edge where en=1, pat_load=0, the fill count after the shift equals PAT_LEN, and the shifted history equals the pattern register.
REQ-017 SHALL drive out=1 for exactly the cycle following the matching edge; out=0 otherwise, including every cycle with en=0.
REQ-018 SHALL, with overlap=1, leave history and fill unchanged after a match so suffix bits count toward the next match.
REQ-019 SHALL, with overlap=0, clear fill to 0 on a match so the next match needs PAT_LEN fresh bits.
REQ-020 SHALL hold history, fill and out=0 on edges with en=0 (gaps do not break a partial sequence).
REQ-021 SHALL, on pat_load=1, load pat, clear fill to 0, drive out=0 next cycle, and discard in that edge even if en=1.
REQ-022 SHALL sample overlap each edge; a change takes effect on the next match only.
REQ-023 SHALL increment match_cnt on each match, saturating at 2^CNT_W-1 (no wrap).
REQ-024 SHALL clear match_cnt to 0 on cnt_clr=1; cnt_clr wins over a same-edge match.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force out=0, match_cnt=0, history=0, fill=0, pattern register=PATTERN.
REQ-026 SHALL, after rst_n deasserts mid-sequence, require PAT_LEN fresh sampled bits before any match.

Configuration
REQ-027 SHALL compile the match counter only when macro PATTERN_DETECTOR_CNT_EN is defined; REQ-023/024 apply as written.
REQ-028 SHALL, without PATTERN_DETECTOR_CNT_EN, drive match_cnt constant 0, ignore cnt_clr, and keep out behaviour identical.

Verification
REQ-029 SHALL cover: defaults, overlap=1, en=1, in=0,1,1,0,1,1,0 -> out pulses the cycle after bits 4 and 7; match_cnt=2.
REQ-030 SHALL cover: same stimulus with overlap=0 -> out pulses only after bit 4; match_cnt=1.
REQ-031 SHALL cover: in=0,1,(en=0 three cycles),1,0 -> single out pulse after the final 0; out=0 during gap.
REQ-032 SHALL cover: pat_load with pat=4'b1001 while en=1, in=1, then in=1,0,0,1 -> pulse after final bit; loaded-edge bit discarded; no match against 0110.
REQ-033 SHALL cover: CNT_W=2, five matches -> match_cnt=3 and holds; cnt_clr on a matching edge -> match_cnt=0, out still pulses.
REQ-034 SHALL cover: rst_n low after bits 0,1,1 then released, in=0 -> no pulse; all outputs 0 during reset without a clock edge.
